board_io_frontend: RTL and testbench

//   Parametrised front end for the board's push-buttons, slide switches and 7-segment displays.
//   - Synchronises and debounces NUM_KEYS keys and NUM_SW switches.
//   - Emits debounced levels plus single-cycle edge pulses.
//   - Drives NUM_HEX 7-seg digits from a loadable hex value, with per-digit and leading-zero blanking.

---
 rtl/board_io_frontend.sv | 166 ++++++++++++++++
 tb/tb_board_io_frontend.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/board_io_frontend.sv
// board_io_frontend
//   Front end between the raw board pins and application logic.
//   - KEY (active-low push-buttons) and SW (slide switches) are passed through a
//     2-flop synchroniser and a per-bit debouncer. Debounced levels and
//     single-cycle press/release/change pulses come out of registers.
//   - The 7-segment path captures a hex value and a blank mask on hex_load.
//     It drives NUM_HEX active-low digits from a registered decode.
//     Leading-zero and per-digit blanking are applied in that decode.
// Ports
//   CLOCK_50        in   system clock, rising edge
//   RESET_N         in   asynchronous active-low reset. Deassertion is expected
//                        to be synchronous to CLOCK_50 (board reset synchroniser)
//   KEY[NUM_KEYS]   in   raw buttons, 0 = pressed
//   SW[NUM_SW]      in   raw switches
//   key_level       out  debounced button state, 1 = pressed
//   key_press       out  one-cycle pulse when key_level rises
//   key_release     out  one-cycle pulse when key_level falls
//   sw_level        out  debounced switch state
//   sw_change       out  one-cycle pulse when sw_level changes
//   hex_value       in   nibble i drives digit i (digit 0 rightmost)
//   hex_load        in   capture hex_value / hex_blank_mask
//   hex_blank_mask  in   1 = force digit off
//   HEX             out  active-low segments, digit i = [7i+6:7i], bit0=a..bit6=g
module board_io_frontend #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 10,
  parameter int NUM_HEX         = 6,
  parameter int DB_CYCLES       = 500000,
  parameter int LEAD_ZERO_BLANK = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [NUM_KEYS-1:0]    KEY,
  input  logic [NUM_SW-1:0]      SW,
  output logic [NUM_KEYS-1:0]    key_level,
  output logic [NUM_KEYS-1:0]    key_press,
  output logic [NUM_KEYS-1:0]    key_release,
  output logic [NUM_SW-1:0]      sw_level,
  output logic [NUM_SW-1:0]      sw_change,
  input  logic [4*NUM_HEX-1:0]   hex_value,
  input  logic                   hex_load,
  input  logic [NUM_HEX-1:0]     hex_blank_mask,
  output logic [7*NUM_HEX-1:0]   HEX
);

  localparam int NUM_IN = NUM_KEYS + NUM_SW;
  localparam int CW     = $clog2(DB_CYCLES);

  // Keys sit in the low bits of the combined input vector. Their sync flops idle
  // at 1 (released) and are inverted after synchronisation, so that the
  // debouncer works on "1 = active" for every bit.
  localparam logic [NUM_IN-1:0] KEY_BITS = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  localparam logic [CW-1:0]     CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NUM_IN-1:0] r_meta;
  logic [NUM_IN-1:0] r_sync;
  logic [NUM_IN-1:0] w_act;
  logic [NUM_IN-1:0] r_stable;
  logic [NUM_IN-1:0] r_rise;
  logic [NUM_IN-1:0] r_fall;
  logic [CW-1:0]     r_cnt [NUM_IN];

  // ---------------------------------------------------------------- inputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_meta <= KEY_BITS;
      r_sync <= KEY_BITS;
    end else begin
      r_meta <= {SW, KEY};
      r_sync <= r_meta;
    end
  end

  assign w_act = r_sync ^ KEY_BITS;

  // The counter tracks consecutive samples that differ from the accepted level.
  // On the sample where it would reach DB_CYCLES, the level flips and the
  // counter clears. The counter therefore never exceeds DB_CYCLES-1.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_act[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= w_act[i];
          r_rise[i]   <= w_act[i];
          r_fall[i]   <= ~w_act[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign key_level   = r_stable[NUM_KEYS-1:0];
  assign key_press   = r_rise[NUM_KEYS-1:0];
  assign key_release = r_fall[NUM_KEYS-1:0];
  assign sw_level    = r_stable[NUM_IN-1:NUM_KEYS];
  assign sw_change   = r_rise[NUM_IN-1:NUM_KEYS] | r_fall[NUM_IN-1:NUM_KEYS];

  // --------------------------------------------------------------- display
  logic [4*NUM_HEX-1:0] r_hex_val;
  logic [NUM_HEX-1:0]   r_hex_mask;
  logic [7*NUM_HEX-1:0] w_hex_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hex_val  <= '0;
      r_hex_mask <= '0;
    end else if (hex_load) begin
      r_hex_val  <= hex_value;
      r_hex_mask <= hex_blank_mask;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HEX; gi++) begin : g_digit
      logic [3:0] w_nib;
      logic       w_upper_zero;
      logic       w_blank;
      assign w_nib        = r_hex_val[4*gi +: 4];
      // This digit and every digit to its left are zero. Digit 0 is excluded
      // below, so that a value of zero still shows "0".
      assign w_upper_zero = (r_hex_val[4*NUM_HEX-1:4*gi] == '0);
      assign w_blank      = r_hex_mask[gi] |
                            ((LEAD_ZERO_BLANK != 0) && (gi != 0) && w_upper_zero);
      assign w_hex_next[7*gi +: 7] = w_blank ? 7'h7F : seg_decode(w_nib);
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) HEX <= '1;
    else          HEX <= w_hex_next;
  end

endmodule

// File: tb/tb_board_io_frontend.sv
module tb_board_io_frontend;
  localparam int NK = 4;
  localparam int NS = 10;
  localparam int NH = 6;
  localparam int DB = 8;

  localparam logic [41:0] H_OFF    = {6{7'h7F}};
  localparam logic [41:0] H_ZERO   = {{5{7'h7F}}, 7'h40};
  localparam logic [41:0] H_A3F    = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E};
  localparam logic [41:0] H_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] H_F000M  = {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
  localparam logic [41:0] H_789BCD = {7'h78, 7'h00, 7'h10, 7'h03, 7'h46, 7'h21};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NS-1:0] sw;
  logic [NK-1:0] key_level, key_press, key_release;
  logic [NS-1:0] sw_level, sw_change;
  logic [4*NH-1:0] hex_value;
  logic          hex_load;
  logic [NH-1:0] hex_blank_mask;
  logic [7*NH-1:0] hex;

  always #5 clk = ~clk;

  board_io_frontend #(
    .NUM_KEYS(NK), .NUM_SW(NS), .NUM_HEX(NH), .DB_CYCLES(DB), .LEAD_ZERO_BLANK(1)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .sw_level(sw_level), .sw_change(sw_change),
    .hex_value(hex_value), .hex_load(hex_load), .hex_blank_mask(hex_blank_mask),
    .HEX(hex)
  );

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] klvl;
    logic [NS-1:0] chg;
    logic [NS-1:0] swlvl;
  } exp_t;

  exp_t sbq[$];
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  logic [NK-1:0] m_klvl;
  logic [NS-1:0] m_swlvl;
  logic [41:0]   prev_hex;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call at a falling edge right after driving key/sw. The new debounced state
  // must appear 2 sync + DB debounce edges later.
  task automatic expect_change();
    exp_t e;
    logic [NK-1:0] nk;
    nk      = ~key;
    e.cyc   = edge_n + DB + 2;
    e.press = nk & ~m_klvl;
    e.rel   = ~nk & m_klvl;
    e.klvl  = nk;
    e.chg   = sw ^ m_swlvl;
    e.swlvl = sw;
    m_klvl  = nk;
    m_swlvl = sw;
    sbq.push_back(e);
    $display("push event edge=%0d press=%b release=%b change=%b", e.cyc, e.press, e.rel, e.chg);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 4 * DB) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(sbq.size()), 64'(0));
    step(3);
  endtask

  task automatic load_hex(input string tag, input logic [23:0] v, input logic [5:0] m,
                          input logic [41:0] expv);
    hex_value      = v;
    hex_blank_mask = m;
    hex_load       = 1'b1;
    step(1);
    hex_load = 1'b0;
    chk({tag, "_hold_n"}, 64'(hex), 64'(prev_hex));
    step(1);
    chk(tag, 64'(hex), 64'(expv));
    $display("hex load value=%h mask=%b HEX=%h", v, m, hex);
    prev_hex = expv;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hex"}, 64'(hex), 64'(H_OFF));
    chk({tag, "_klvl"}, 64'(key_level), 64'(0));
    chk({tag, "_kpulse"}, 64'({key_press, key_release}), 64'(0));
    chk({tag, "_swlvl"}, 64'(sw_level), 64'(0));
    chk({tag, "_swchg"}, 64'(sw_change), 64'(0));
  endtask

  // Scoreboard: pops the expected event on its edge and otherwise demands that
  // no pulse is present.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && mon_en) begin
      if (sbq.size() > 0 && sbq[0].cyc < edge_n) begin
        n_checks++;
        n_fail++;
        $error("FAIL missed_event observed=none expected=edge %0d (now %0d)", sbq[0].cyc, edge_n);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == edge_n) begin
        e = sbq.pop_front();
        chk("key_press", 64'(key_press), 64'(e.press));
        chk("key_release", 64'(key_release), 64'(e.rel));
        chk("key_level", 64'(key_level), 64'(e.klvl));
        chk("sw_change", 64'(sw_change), 64'(e.chg));
        chk("sw_level", 64'(sw_level), 64'(e.swlvl));
        $display("event edge=%0d press=%b release=%b change=%b level=%b", edge_n,
                 key_press, key_release, sw_change, key_level);
      end else begin
        chk("idle_pulses", 64'({key_press, key_release, sw_change}), 64'(0));
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; key = '1; sw = '0;
    hex_value = '0; hex_load = 1'b0; hex_blank_mask = '0;
    m_klvl = '0; m_swlvl = '0;

    // 1. reset state, then quiet after release
    step(3);
    chk_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(2);
    prev_hex = H_ZERO;
    chk("post_reset_hex", 64'(hex), 64'(H_ZERO));
    step(100);

    // 2. press / release latency on KEY[0]
    key[0] = 1'b0; expect_change();
    drain("k0_press_drain");
    key[0] = 1'b1; expect_change();
    drain("k0_release_drain");

    // 3. bounce shorter than DB on KEY[1] is ignored, then a real press
    key[1] = 1'b0; step(5);
    key[1] = 1'b1; step(2);
    key[1] = 1'b0; step(5);
    key[1] = 1'b1; step(15);
    chk("bounce_level", 64'(key_level), 64'(0));
    key[1] = 1'b0; expect_change();
    drain("k1_press_drain");
    key[1] = 1'b1; expect_change();
    drain("k1_release_drain");

    // 4. display path
    load_hex("hex_a3f", 24'h000A3F, 6'b000000, H_A3F);
    hex_value = 24'h123456;
    step(3);
    chk("hex_no_load_hold", 64'(hex), 64'(H_A3F));
    load_hex("hex_123456", 24'h123456, 6'b000000, H_123456);
    load_hex("hex_789bcd", 24'h789BCD, 6'b000000, H_789BCD);
    load_hex("hex_zero", 24'h000000, 6'b000000, H_ZERO);
    load_hex("hex_mask_d0", 24'h000000, 6'b000001, H_OFF);
    load_hex("hex_f000_mask3", 24'h00F000, 6'b001000, H_F000M);

    // 6. simultaneous changes pulse together
    key[0] = 1'b0; key[3] = 1'b0; sw[9] = 1'b1; expect_change();
    drain("simul_drain");

    // 5. reset in the middle of a KEY[2] debounce
    key[2] = 1'b0;
    step(DB - 1);
    chk("mid_db_level", 64'(key_level[2]), 64'(0));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    m_klvl = '0; m_swlvl = '0;
    step(2);
    rst_n = 1'b1;
    expect_change();
    drain("post_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
